// File: rtl/memstream_reader_if.sv
// Bundles the memory read port and AXI-Stream master signals of memstream_reader.
// The reader owns the master modport; the RAM and stream sink sit on the slave modport.
interface memstream_reader_if #(
  parameter int DWIDTH = 18,
  parameter int AWIDTH = 10
);
  logic              mem_en;
  logic              mem_enq;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_rdq;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    output mem_en, mem_enq, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  mem_rdq, m_axis_tready
  );

  modport slave (
    input  mem_en, mem_enq, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output mem_rdq, m_axis_tready
  );
endinterface

// File: rtl/memstream_reader.sv
// Streams a RAM with a two-stage registered read port out over AXI-Stream,
// cycling through addresses 0..NWORDS-1 and counting completed passes.
module memstream_reader #(
  parameter int DWIDTH = 18,
  parameter int AWIDTH = 10,
  parameter int NWORDS = 2**AWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  memstream_reader_if.master  bus,
  output logic [15:0]         pass_count
);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NWORDS - 1);

  logic              v1, v2;
  logic              last1, last2;
  logic              adv, en, enq;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] rdq;

  // Stage 2 advances whenever its word is consumed or absent; stage 1 refills
  // alongside it or whenever it is empty, so a full stalled pipe freezes the RAM.
  always_comb begin
    adv = bus.m_axis_tready | ~v2;
    enq = ~rst & adv;
    en  = ~rst & (adv | ~v1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      last1      <= 1'b0;
      last2      <= 1'b0;
      addr       <= '0;
      pass_count <= '0;
    end else begin
      if (enq) begin
        v2    <= v1;
        last2 <= last1;
      end
      if (en) begin
        v1    <= 1'b1;
        last1 <= (addr == LAST_ADDR);
        addr  <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
      end
      if (v2 && bus.m_axis_tready && last2)
        pass_count <= pass_count + 16'd1;
    end
  end

  assign rdq               = bus.mem_rdq;
  assign bus.m_axis_tdata  = rdq;
  assign bus.m_axis_tvalid = v2;
  assign bus.m_axis_tlast  = last2 & v2;
  assign bus.mem_en        = en;
  assign bus.mem_enq       = enq;
  assign bus.mem_addr      = addr;
endmodule

// File: tb/tb_memstream_reader.sv
// Bench for memstream_reader: two instances (NWORDS=8 and NWORDS=2) over a
// behavioural two-stage RAM holding word[i]=i, checked against an expected-sequence model.
module tb_memstream_reader;
  logic clk;
  logic rst_a, rst_b;
  logic [15:0] pass_a, pass_b;

  memstream_reader_if #(.DWIDTH(18), .AWIDTH(10)) bus_a ();
  memstream_reader_if #(.DWIDTH(18), .AWIDTH(10)) bus_b ();

  memstream_reader #(.DWIDTH(18), .AWIDTH(10), .NWORDS(8)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a.master), .pass_count(pass_a)
  );
  memstream_reader #(.DWIDTH(18), .AWIDTH(10), .NWORDS(2)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.master), .pass_count(pass_b)
  );

  always #5 clk = ~clk;

  // RAM: internal read register loads on ena, output register on enqa; word[i] = i.
  logic [17:0] reg1_a, reg1_b;
  always @(posedge clk) begin
    if (bus_a.mem_en)  reg1_a <= 18'(bus_a.mem_addr);
    if (bus_a.mem_enq) bus_a.mem_rdq <= reg1_a;
    if (bus_b.mem_en)  reg1_b <= 18'(bus_b.mem_addr);
    if (bus_b.mem_enq) bus_b.mem_rdq <= reg1_b;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected stream state per instance: next word, passes, beats, stall capture.
  int          nwords[2] = '{8, 2};
  int          exp_k[2];
  int          exp_pass[2];
  int          beats[2];
  bit          stall[2];
  logic [17:0] pdata[2];
  logic        plast[2];
  bit          last_beat[2];
  int          cyc = 0;
  int          last_pass_cyc = -1;
  int          rel_cnt = 0;
  bit          prev_rst_a = 1'b1;

  task automatic clear_model(input int i);
    exp_k[i] = 0; exp_pass[i] = 0; beats[i] = 0; stall[i] = 1'b0; last_beat[i] = 1'b0;
  endtask

  task automatic model(input int i, input logic tv, input logic tr, input logic [17:0] td,
                       input logic tl, input logic [15:0] pc);
    check($sformatf("pass%0d", i), 32'(pc), 32'(exp_pass[i] % 65536));
    if (stall[i]) begin
      check($sformatf("hold_v%0d", i), 32'(tv), 32'd1);
      check($sformatf("hold_d%0d", i), 32'(td), 32'(pdata[i]));
      check($sformatf("hold_l%0d", i), 32'(tl), 32'(plast[i]));
    end
    if (!tv) check($sformatf("last_nv%0d", i), 32'(tl), 32'd0);
    stall[i]     = tv && !tr;
    pdata[i]     = td;
    plast[i]     = tl;
    last_beat[i] = tv && tr;
    if (tv && tr) begin
      check($sformatf("data%0d", i), 32'(td), 32'(exp_k[i]));
      check($sformatf("tlast%0d", i), 32'(tl), 32'(exp_k[i] == nwords[i] - 1));
      if (exp_k[i] == nwords[i] - 1) begin
        exp_pass[i]++;
        if (i == 1) begin
          if (last_pass_cyc >= 0) check("pass_gap1", 32'(cyc - last_pass_cyc), 32'd4);
          last_pass_cyc = cyc;
        end
      end
      exp_k[i] = (exp_k[i] + 1) % nwords[i];
      beats[i]++;
    end
  endtask

  // One cycle: drive inputs at the falling edge, sample 1 time unit later.
  task automatic step(input bit ra, input bit rs);
    @(negedge clk);
    rst_a = rs;
    bus_a.m_axis_tready = ra;
    bus_b.m_axis_tready = ~bus_b.m_axis_tready;
    cyc++;
    #1;
    if (rs) begin
      check("rst_en", 32'(bus_a.mem_en), 32'd0);
      check("rst_enq", 32'(bus_a.mem_enq), 32'd0);
      clear_model(0);
      rel_cnt = 0;
    end else begin
      rel_cnt++;
      if (prev_rst_a) begin
        check("rst_tvalid", 32'(bus_a.m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(bus_a.m_axis_tlast), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_addr", 32'(bus_a.mem_addr), 32'd0);
      end
      if (rel_cnt == 2) check("lat_e1", 32'(bus_a.m_axis_tvalid), 32'd0);
      if (rel_cnt == 3) check("lat_e2", 32'(bus_a.m_axis_tvalid), 32'd1);
      model(0, bus_a.m_axis_tvalid, bus_a.m_axis_tready, bus_a.m_axis_tdata,
            bus_a.m_axis_tlast, pass_a);
    end
    prev_rst_a = rs;
    model(1, bus_b.m_axis_tvalid, bus_b.m_axis_tready, bus_b.m_axis_tdata,
          bus_b.m_axis_tlast, pass_b);
  endtask

  task automatic run_until_beats(input int target, input string tag);
    int n = 0;
    while (beats[0] < target && n < 200) begin
      step(1'b1, 1'b0);
      n++;
    end
    if (beats[0] < target) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.m_axis_tready = 1'b0;
    bus_b.m_axis_tready = 1'b0;
    clear_model(0);
    clear_model(1);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;

    // Full-rate streaming: 16 beats, two passes.
    step(1'b1, 1'b1);
    run_until_beats(16, "timeout_t1");
    step(1'b0, 1'b0);
    check("pass_after16", 32'(pass_a), 32'd2);

    // Random backpressure, ~30% ready.
    step(1'b1, 1'b1);
    repeat (300) step($urandom_range(0, 99) < 30, 1'b0);

    // Hold tready low from release: pipe fills and freezes, then drains back-to-back.
    step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    check("fill_addr", 32'(bus_a.mem_addr), 32'd2);
    check("fill_en", 32'(bus_a.mem_en), 32'd0);
    check("fill_enq", 32'(bus_a.mem_enq), 32'd0);
    repeat (3) begin
      step(1'b1, 1'b0);
      check("b2b_beat", 32'(last_beat[0]), 32'd1);
    end

    // Reset pulse mid-pass after beat 5, then restart from word 0.
    step(1'b1, 1'b1);
    run_until_beats(6, "timeout_t4a");
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    run_until_beats(3, "timeout_t4b");
    check("pass_after_rst", 32'(pass_a), 32'd0);

    check("b_passes_seen", 32'(exp_pass[1] > 10), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memstream_reader.md
MEMSTREAM_READER -- requirements
Module: memstream_reader

Interface
REQ-001 SHALL provide parameter DWIDTH, default 18, the word width of the memory and of the stream.
REQ-002 SHALL provide parameter AWIDTH, default 10, the memory address width.
REQ-003 SHALL provide parameter NWORDS, default 2**AWIDTH, the words per pass; legal range 2..2**AWIDTH.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL provide port mem_en, output, 1 bit: drives the memory-port read enable (the RAM's `ena`).
REQ-007 SHALL provide port mem_enq, output, 1 bit: drives the RAM output-register enable (`enqa`).
REQ-008 SHALL provide port mem_addr, output, AWIDTH bits: the read address.
REQ-009 SHALL provide port mem_rdq, input, DWIDTH bits: the registered read data (`rdqa`).
REQ-010 SHALL provide port m_axis_tdata, output, DWIDTH bits: the stream data, wired directly from mem_rdq.
REQ-011 SHALL provide port m_axis_tvalid, output, 1 bit: stream valid.
REQ-012 SHALL provide port m_axis_tready, input, 1 bit: stream ready from downstream.
REQ-013 SHALL provide port m_axis_tlast, output, 1 bit: marks the word read from address NWORDS-1.
REQ-014 SHALL provide port pass_count, output, 16 bits: number of completed passes, wrapping modulo 2**16.
REQ-015 SHALL keep the memory write-enable tied to 0 outside this block; this block never writes.

Function
REQ-016 SHALL model the memory as a 2-stage pipeline with internal flags v1 and v2.
- v1: the RAM internal read register holds a valid word (loaded when mem_en=1).
- v2: mem_rdq holds a valid word (loaded when mem_enq=1).
REQ-017 SHALL drive m_axis_tvalid = v2.
REQ-018 SHALL compute adv = m_axis_tready OR NOT v2.
REQ-019 SHALL drive mem_enq = adv.
REQ-020 SHALL drive mem_en = adv OR NOT v1.
REQ-021 SHALL update the flags on each edge:
- v2 <= v1 when adv=1; v2 holds otherwise.
- v1 <= 1 when mem_en=1; v1 holds otherwise.
REQ-022 SHALL increment mem_addr on every edge where mem_en=1.
- Wrap-around: NWORDS-1 goes to 0.
- Otherwise mem_addr holds.
REQ-023 SHALL carry a tlast flag alongside the data through both pipeline stages.
- The flag is set for the word issued at address NWORDS-1.
- It advances under the same enables as v1 and v2.
REQ-024 SHALL drive m_axis_tlast = stage-2 flag AND v2.
REQ-025 SHALL increment pass_count by 1 on each edge where m_axis_tvalid, m_axis_tready and m_axis_tlast are all 1.
REQ-026 SHALL hold m_axis_tdata and m_axis_tlast stable while tvalid=1 and tready=0 (AXI-Stream rule).
REQ-027 SHALL neither drop nor duplicate words under any tready pattern; words appear in strict address order 0..NWORDS-1, repeating.
REQ-028 SHALL, with tready held at 1, have latency 2:
- First valid beat appears 2 edges after the first edge with rst=0.
- Throughput is then 1 word/cycle with no bubbles, including across wrap.
REQ-029 SHALL, when tready falls with both stages full, have mem_en=0 and mem_enq=0 so the RAM state freezes.
REQ-030 SHALL, when tready rises again, emit the frozen word first, with no gap cycle.

Reset
REQ-031 SHALL, while rst=1 at an edge, clear v1, v2, both tlast flags, mem_addr (to 0) and pass_count (to 0).
REQ-032 SHALL hold m_axis_tvalid=0 and m_axis_tlast=0 during reset.
REQ-033 SHALL force mem_en=0 and mem_enq=0 while rst=1.
REQ-034 SHALL, on reset asserted mid-pass, discard in-flight words; after release the stream restarts at address 0.

Verification
REQ-035 Bench: NWORDS=8, memory init word[i]=i, tready=1 -> tdata 0,1,..,7,0,1..., tvalid from the 2nd edge after reset release, tlast on every 7, pass_count=2 after 16 beats.
REQ-036 Bench: tready pseudo-random at 30% -> accepted sequence identical to REQ-035; tdata/tlast stable during every stall.
REQ-037 Bench: tready=0 from reset release for 10 cycles -> mem_addr stops at 2, mem_en=mem_enq=0 after fill; first beat when tready=1 is 0, followed back-to-back by 1,2.
REQ-038 Bench: rst pulsed for 1 cycle after beat 5 -> tvalid=0 the next cycle; the stream resumes with 0; pass_count=0.
REQ-039 Bench: NWORDS=2 with tready toggling 1/0 every cycle -> accepted beats alternate 0,1 with tlast on 1; pass_count increments every 4 cycles.
